// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_fetch_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned FETCH_ADDR_W  = 64;
    localparam int unsigned FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO; flush overrides any push or pop in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && !flush && ((count < CNT_W'(DEPTH)) || do_pop);
    end

    assign head = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch front end: PC generation, single-outstanding imem request, decode queue, redirect flush.
module fetch_queue_stage
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned            ADDR_W   = 64,
    parameter int unsigned            INSTR_W  = 32,
    parameter int unsigned            DEPTH    = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [ADDR_W-1:0]   id_pc,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t               state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    logic [ADDR_W-1:0]          held_q, held_d;
    logic [ADDR_W-1:0]          target;
    logic [CNT_W-1:0]           count;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic [ADDR_W+INSTR_W-1:0]  head;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            held_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        held_d  = held_q;
        push    = 1'b0;
        flush   = 1'b0;
        pop     = id_valid && id_ready;
        target  = redirect_pc & ~ADDR_W'(3);
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = target;
                    state_d = REQ;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = target;
                    if (!imem_ack) begin
                        held_d  = pc_q;
                        state_d = DISCARD;
                    end
                end else if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(INSTR_BYTES);
                    // Without a same-cycle pop this push may fill the last slot.
                    if (!pop && (count == CNT_W'(DEPTH - 1))) begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = target;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DISCARD) ? held_q : pc_q;
    assign id_valid  = (count != '0);
    assign id_pc     = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign id_instr  = head[INSTR_W-1:0];

    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({pc_q, imem_rdata}),
        .head  (head),
        .count (count)
    );

endmodule
